// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 compression core: UNROLL rounds per clock over a 16-word
// sliding message-schedule window, with optional feedforward of the initial state.
module sha256_iter_core #(
  parameter int NUM_ROUNDS  = 64,
  parameter int UNROLL      = 1,
  parameter int FEEDFORWARD = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic [255:0] i_state,
  input  logic [511:0] i_data,
  output logic         o_ready,
  output logic         o_busy,
  output logic         o_valid,
  output logic [255:0] o_hash,
  output logic [31:0]  o_fold
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 64 ||
      !(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8) ||
      (NUM_ROUNDS % UNROLL) != 0) begin : g_paramCheck
    $error("sha256_iter_core: illegal NUM_ROUNDS/UNROLL combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bigSigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bigSigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] smallSigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] smallSigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] choose(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] majority(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  state_t       r_state;
  state_t       w_nextState;
  logic [6:0]   r_round;
  logic [31:0]  r_work [0:7];
  logic [31:0]  r_ff   [0:7];
  logic [31:0]  r_win  [0:15];
  logic [255:0] r_hash;
  logic [31:0]  r_fold;

  logic [31:0]  w_ext     [0:15+UNROLL];
  logic [31:0]  w_winNext [0:15];
  logic [31:0]  w_stage   [0:UNROLL][0:7];
  logic [31:0]  w_t1      [0:UNROLL-1];
  logic [31:0]  w_t2      [0:UNROLL-1];
  logic [255:0] w_result;
  logic [31:0]  w_foldNext;
  logic         w_accept;
  logic         w_last;

  assign w_accept = o_ready & i_start;
  assign w_last   = (r_round == 7'(NUM_ROUNDS - UNROLL));
  assign o_hash   = r_hash;
  assign o_fold   = r_fold;

  // w_ext[i] holds W[r+i]; the top UNROLL entries are this cycle's freshly expanded words.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_ext[i] = r_win[i];
    end
    for (int j = 0; j < UNROLL; j++) begin
      w_ext[16+j] = smallSigma1(w_ext[14+j]) + w_ext[9+j] + smallSigma0(w_ext[1+j]) + w_ext[j];
    end
    for (int i = 0; i < 16; i++) begin
      w_winNext[i] = w_ext[i+UNROLL];
    end
  end

  always_comb begin
    w_stage[0] = r_work;
    for (int j = 0; j < UNROLL; j++) begin
      w_t1[j] = w_stage[j][7] + bigSigma1(w_stage[j][4])
              + choose(w_stage[j][4], w_stage[j][5], w_stage[j][6])
              + K[r_round[5:0] + 6'(j)] + w_ext[j];
      w_t2[j] = bigSigma0(w_stage[j][0]) + majority(w_stage[j][0], w_stage[j][1], w_stage[j][2]);
      w_stage[j+1][0] = w_t1[j] + w_t2[j];
      w_stage[j+1][1] = w_stage[j][0];
      w_stage[j+1][2] = w_stage[j][1];
      w_stage[j+1][3] = w_stage[j][2];
      w_stage[j+1][4] = w_stage[j][3] + w_t1[j];
      w_stage[j+1][5] = w_stage[j][4];
      w_stage[j+1][6] = w_stage[j][5];
      w_stage[j+1][7] = w_stage[j][6];
    end
  end

  always_comb begin
    w_result   = '0;
    w_foldNext = '0;
    for (int k = 0; k < 8; k++) begin
      w_result[32*k +: 32] = w_stage[UNROLL][k] + ((FEEDFORWARD != 0) ? r_ff[k] : 32'h0);
      w_foldNext = w_foldNext ^ w_result[32*k +: 32];
    end
  end

  always_comb begin
    w_nextState = r_state;
    o_ready     = 1'b0;
    o_busy      = 1'b0;
    o_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) w_nextState = RUN;
      end
      RUN: begin
        o_busy = 1'b1;
        if (w_last) w_nextState = DONE;
      end
      DONE: begin
        o_ready = 1'b1;
        o_valid = 1'b1;
        if (i_start) w_nextState = RUN;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_round <= '0;
      r_hash  <= '0;
      r_fold  <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_round <= '0;
      end else if (r_state == RUN) begin
        r_round <= r_round + 7'(UNROLL);
        if (w_last) begin
          r_hash <= w_result;
          r_fold <= w_foldNext;
        end
      end
    end
  end

  // Datapath has no reset: a stray capture during reset is harmless because the FSM is forced to IDLE.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < 8; k++) begin
        r_work[k] <= i_state[32*k +: 32];
        r_ff[k]   <= i_state[32*k +: 32];
      end
      for (int i = 0; i < 16; i++) begin
        r_win[i] <= i_data[32*i +: 32];
      end
    end else if (r_state == RUN) begin
      r_work <= w_stage[UNROLL];
      r_win  <= w_winNext;
    end
  end

endmodule

// File: tb/tb_sha256_iter_core.sv
// Scoreboard bench for sha256_iter_core: four configurations share a clock and reset,
// expected hashes come from a plain SHA-256 reference model and are checked by per-instance monitors.
module tb_sha256_iter_core;

  localparam int NR_TB  [4] = '{64, 64, 64, 32};
  localparam int UR_TB  [4] = '{1, 4, 8, 2};
  localparam int FF_TB  [4] = '{1, 1, 1, 0};
  localparam int LAT_TB [4] = '{64, 16, 8, 16};

  localparam logic [31:0] K_TB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV_TB = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [511:0] ABC_BLOCK = {32'h00000018, 448'h0, 32'h61626380};
  localparam logic [255:0] ABC_HASH = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                       32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};

  typedef struct {
    logic [255:0] hash;
    logic [31:0]  fold;
    int           acceptEdge;
  } expEntry_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         startSig [4];
  logic [255:0] stateIn  [4];
  logic [511:0] dataIn   [4];
  logic         readyO   [4];
  logic         busyO    [4];
  logic         validO   [4];
  logic [255:0] hashO    [4];
  logic [31:0]  foldO    [4];

  expEntry_t    sbQ [4][$];
  logic [255:0] lastExpHash [4] = '{default: '0};
  bit           periodCheck [4] = '{default: 1'b0};
  int           lastRise    [4] = '{default: -1};
  int           cycleCount = 0;
  int           nVectors = 0;
  int           nMiscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  sha256_iter_core #(.NUM_ROUNDS(64), .UNROLL(1), .FEEDFORWARD(1)) u_dutDefault (
    .clk(clk), .reset(reset), .i_start(startSig[0]), .i_state(stateIn[0]), .i_data(dataIn[0]),
    .o_ready(readyO[0]), .o_busy(busyO[0]), .o_valid(validO[0]), .o_hash(hashO[0]), .o_fold(foldO[0]));

  sha256_iter_core #(.NUM_ROUNDS(64), .UNROLL(4), .FEEDFORWARD(1)) u_dutUnroll4 (
    .clk(clk), .reset(reset), .i_start(startSig[1]), .i_state(stateIn[1]), .i_data(dataIn[1]),
    .o_ready(readyO[1]), .o_busy(busyO[1]), .o_valid(validO[1]), .o_hash(hashO[1]), .o_fold(foldO[1]));

  sha256_iter_core #(.NUM_ROUNDS(64), .UNROLL(8), .FEEDFORWARD(1)) u_dutUnroll8 (
    .clk(clk), .reset(reset), .i_start(startSig[2]), .i_state(stateIn[2]), .i_data(dataIn[2]),
    .o_ready(readyO[2]), .o_busy(busyO[2]), .o_valid(validO[2]), .o_hash(hashO[2]), .o_fold(foldO[2]));

  sha256_iter_core #(.NUM_ROUNDS(32), .UNROLL(2), .FEEDFORWARD(0)) u_dutTrunc32 (
    .clk(clk), .reset(reset), .i_start(startSig[3]), .i_state(stateIn[3]), .i_data(dataIn[3]),
    .o_ready(readyO[3]), .o_busy(busyO[3]), .o_valid(validO[3]), .o_hash(hashO[3]), .o_fold(foldO[3]));

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: expand the whole schedule first, then run the requested number of rounds.
  function automatic logic [255:0] refCompress(input logic [255:0] st, input logic [511:0] blk,
                                               input int rounds, input int ff);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  s0, s1, t1, t2, ch, mj;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = st[32*i +: 32];
    for (int t = 0; t < rounds; t++) begin
      ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
      mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ch + K_TB[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + mj;
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[32*i +: 32] = v[i] + ((ff != 0) ? st[32*i +: 32] : 32'h0);
    return res;
  endfunction

  function automatic logic [31:0] foldOf(input logic [255:0] h);
    logic [31:0] f = '0;
    for (int i = 0; i < 8; i++) f = f ^ h[32*i +: 32];
    return f;
  endfunction

  function automatic logic [255:0] randState();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [511:0] randBlock();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Called at the negedge before the accepting edge, so that edge is cycleCount+1.
  task automatic pushExpected(input int inst, input logic [255:0] st, input logic [511:0] blk,
                              input bit useGiven, input logic [255:0] given);
    expEntry_t e;
    e.hash = useGiven ? given : refCompress(st, blk, NR_TB[inst], FF_TB[inst]);
    e.fold = foldOf(e.hash);
    e.acceptEdge = cycleCount + 1;
    sbQ[inst].push_back(e);
  endtask

  task automatic applyStimulus(input int inst, input logic [255:0] st, input logic [511:0] blk,
                               input bit push, input bit useGiven, input logic [255:0] given);
    int n = 0;
    @(negedge clk);
    while (!readyO[inst] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!readyO[inst]) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL readyTimeout inst%0d: o_ready=0, required 1", inst);
    end else begin
      stateIn[inst]  = st;
      dataIn[inst]   = blk;
      startSig[inst] = 1'b1;
      if (push) pushExpected(inst, st, blk, useGiven, given);
      @(negedge clk);
      startSig[inst] = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sbQ[0].size() + sbQ[1].size() + sbQ[2].size() + sbQ[3].size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drainPending", 256'(sbQ[0].size() + sbQ[1].size() + sbQ[2].size() + sbQ[3].size()), 256'd0);
    repeat (2) @(negedge clk);
  endtask

  // A result is taken on each rising o_valid; the visible-after edge is T+LAT, i.e. first sampled by edge T+1+LAT.
  for (genvar g = 0; g < 4; g++) begin : g_mon
    bit prevValid = 1'b0;
    always @(negedge clk) begin
      expEntry_t e;
      if (validO[g] && !prevValid) begin
        if (sbQ[g].size() == 0) begin
          nVectors++;
          nMiscompares++;
          $display("[TB] FAIL unexpectedValid inst%0d: o_valid=1, required 0 at cycle %0d", g, cycleCount);
        end else begin
          e = sbQ[g].pop_front();
          lastExpHash[g] = e.hash;
          checkOutput($sformatf("hash inst%0d", g), hashO[g], e.hash);
          checkOutput($sformatf("fold inst%0d", g), 256'(foldO[g]), 256'(e.fold));
          checkOutput($sformatf("latency inst%0d", g), 256'(cycleCount - e.acceptEdge), 256'(LAT_TB[g]));
          if (periodCheck[g] && lastRise[g] >= 0)
            checkOutput($sformatf("period inst%0d", g), 256'(cycleCount - lastRise[g]), 256'(LAT_TB[g] + 1));
          lastRise[g] = cycleCount;
        end
      end
      prevValid = validO[g];
    end
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      startSig[i] = 1'b0;
      stateIn[i]  = '0;
      dataIn[i]   = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("resetReady inst%0d", i), 256'(readyO[i]), 256'd1);
      checkOutput($sformatf("resetBusy inst%0d", i), 256'(busyO[i]), 256'd0);
      checkOutput($sformatf("resetValid inst%0d", i), 256'(validO[i]), 256'd0);
      checkOutput($sformatf("resetHash inst%0d", i), hashO[i], 256'd0);
      checkOutput($sformatf("resetFold inst%0d", i), 256'(foldO[i]), 256'd0);
    end
    reset = 1'b0;

    $display("[TB] abc vector on all configurations");
    for (int i = 0; i < 3; i++) applyStimulus(i, IV_TB, ABC_BLOCK, 1'b1, 1'b1, ABC_HASH);
    applyStimulus(3, IV_TB, ABC_BLOCK, 1'b1, 1'b0, '0);
    waitDrain();

    $display("[TB] random blocks");
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) applyStimulus(i, randState(), randBlock(), 1'b1, 1'b0, '0);
    waitDrain();

    $display("[TB] start pulses during RUN are ignored");
    applyStimulus(0, randState(), randBlock(), 1'b1, 1'b0, '0);
    for (int p = 0; p < 2; p++) begin
      repeat ((p == 0) ? 9 : 19) @(negedge clk);
      stateIn[0]  = randState();
      dataIn[0]   = randBlock();
      startSig[0] = 1'b1;
      checkOutput("runBusy", 256'(busyO[0]), 256'd1);
      checkOutput("runReady", 256'(readyO[0]), 256'd0);
      checkOutput("runHoldsOldHash", hashO[0], lastExpHash[0]);
      @(negedge clk);
      startSig[0] = 1'b0;
    end
    waitDrain();

    $display("[TB] reset during RUN");
    applyStimulus(0, randState(), randBlock(), 1'b0, 1'b0, '0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    startSig[0] = 1'b1;
    @(negedge clk);
    checkOutput("abortValid", 256'(validO[0]), 256'd0);
    checkOutput("abortBusy", 256'(busyO[0]), 256'd0);
    checkOutput("abortReady", 256'(readyO[0]), 256'd1);
    checkOutput("abortHash", hashO[0], 256'd0);
    checkOutput("abortFold", 256'(foldO[0]), 256'd0);
    reset = 1'b0;
    startSig[0] = 1'b0;
    applyStimulus(0, randState(), randBlock(), 1'b1, 1'b0, '0);
    waitDrain();

    $display("[TB] start held high for three results");
    periodCheck[0] = 1'b1;
    lastRise[0] = -1;
    startSig[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      while (!readyO[0] && n < 500) begin
        @(negedge clk);
        n++;
      end
      checkOutput("heldReady", 256'(readyO[0]), 256'd1);
      if (k == 3) break;
      stateIn[0] = randState();
      dataIn[0]  = randBlock();
      pushExpected(0, stateIn[0], dataIn[0], 1'b0, '0);
      @(negedge clk);
    end
    startSig[0] = 1'b0;
    waitDrain();
    periodCheck[0] = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/sha256_iter_core.md
SHA256_ITER_CORE -- requirements
Module: sha256_iter_core

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 64: number of SHA-256 rounds executed, legal range 1..64.
REQ-002 SHALL have parameter UNROLL, default 1: rounds computed per clock, legal values 1, 2, 4 or 8.
REQ-003 SHALL have parameter FEEDFORWARD, default 1: when 1, add the initial state into the final state; when 0, output the raw working state.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_start, input, 1 bit: request to start a compression.
REQ-007 SHALL have port i_state, input, 256 bits: initial state; word k is bits [32k+31:32k], where word 0 = a and word 7 = h.
REQ-008 SHALL have port i_data, input, 512 bits: message block; word k is bits [32k+31:32k], where word 0 = W0.
REQ-009 SHALL have port o_ready, output, 1 bit: high when i_start will be accepted.
REQ-010 SHALL have port o_busy, output, 1 bit: high while rounds are in progress.
REQ-011 SHALL have port o_valid, output, 1 bit: o_hash and o_fold are valid.
REQ-012 SHALL have port o_hash, output, 256 bits: result, using the same word packing as i_state.
REQ-013 SHALL have port o_fold, output, 32 bits: XOR of the eight 32-bit words of o_hash.

Function
REQ-014 SHALL cause an elaboration-time error when NUM_ROUNDS is not divisible by UNROLL, or when either parameter is outside its legal range.
REQ-015 SHALL implement the FSM states IDLE, RUN and DONE; o_ready = (IDLE or DONE), o_busy = RUN, o_valid = DONE.
REQ-016 SHALL, on any edge with o_ready=1 and i_start=1:
- capture i_state into both the working registers and the feedforward registers;
- capture i_data into a 16-word schedule window;
- clear the round counter to 0;
- enter RUN.
REQ-017 SHALL ignore i_start while in RUN: no capture, no restart, no error flag.
REQ-018 SHALL, on each RUN edge, apply UNROLL consecutive standard SHA-256 rounds r..r+UNROLL-1 (with K[r] and W[r]), then advance the round counter by UNROLL.
REQ-019 SHALL generate the message schedule in the sliding window: W[t] = S1(W[t-2]) + W[t-7] + S0(W[t-15]) + W[t-16] mod 2^32 for t >= 16, producing UNROLL new words per RUN cycle.
REQ-020 SHALL perform all additions modulo 2^32 with no carry between words.
REQ-021 SHALL enter DONE after the edge that completes round NUM_ROUNDS-1; on that edge o_hash = working + feedforward (per word, mod 2^32) when FEEDFORWARD=1, otherwise working.
REQ-022 SHALL register o_fold on the same edge as o_hash, so both change together.
REQ-023 SHALL produce latency as follows: i_start sampled at edge T gives o_valid high from edge T+1+NUM_ROUNDS/UNROLL (65 cycles for the defaults).
REQ-024 SHALL hold o_valid, o_hash and o_fold stable in DONE until the next accepted start or a reset.
REQ-025 SHALL, on a start accepted in DONE, drop o_valid on the next edge and keep o_hash/o_fold at their old values until the new result is written.
REQ-026 SHALL support back-to-back operation: a start held high continuously yields one result every 1+NUM_ROUNDS/UNROLL cycles.
REQ-027 SHALL keep the round counter 7 bits wide and never wrap past NUM_ROUNDS.
REQ-028 SHALL ignore i_state and i_data on every edge that does not accept a start.

Reset
REQ-029 SHALL, on any edge with reset=1, force: FSM to IDLE, round counter 0, o_valid 0, o_busy 0, o_ready 1 (after the edge), o_hash 0, o_fold 0.
REQ-030 SHALL give reset priority over i_start on the same edge: the start is discarded.
REQ-031 SHALL, on reset during RUN, abort the compression with no partial result visible; the next start begins a fresh operation.
REQ-032 SHALL NOT require a reset value on the working, feedforward or schedule registers.

Verification
REQ-033 SHALL cover the "abc" test at defaults: i_state = IV (word0 0x6a09e667 .. word7 0x5be0cd19); i_data W0=0x61626380, W1..W14=0, W15=0x00000018; start at edge T -> o_valid at T+65, o_hash word0=0xba7816bf, word7=0xf20015ad.
REQ-034 SHALL cover the same "abc" vector with UNROLL=4 -> identical o_hash, o_valid at T+17; with UNROLL=8 -> identical o_hash, o_valid at T+9.
REQ-035 SHALL cover NUM_ROUNDS=32 with FEEDFORWARD=0 and random state/data: o_hash and o_fold match the C reference model truncated to 32 rounds, and o_fold equals the XOR of the o_hash words.
REQ-036 SHALL cover i_start pulsed at cycles 10 and 30 of a RUN -> the second pulse is ignored and the result matches the first block only.
REQ-037 SHALL cover reset asserted at RUN cycle 20, followed by a new start -> o_valid stays 0 during the aborted run, and the new result is correct with nominal latency.
REQ-038 SHALL cover i_start held high for 3 results -> three o_valid windows exactly 65 cycles apart, each hash correct.
